// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 single to signed 32-bit integer, round toward zero.
// Accepts the divider's result stream and shifts the mantissa one bit per
// cycle into integer position. Exceptions (NaN, +/-inf, out of range) raise
// output_z_exc and return the overflow value.
// Build option: define F2I_SATURATE_EN to return saturated values
// (+max / -max / 0 for NaN) instead of 32'h80000000 on exceptions.
//
// state          | meaning
// ---------------+------------------------------------------------------
// GET_A          | ack high, waiting for an operand
// UNPACK         | split operand into mantissa, unbiased exponent, sign
// SPECIAL_CASES  | NaN/inf, |x|<1, exactly -2^31, and overflow resolved
// CONVERT        | shift mantissa right one bit per cycle until e == 31
// PACK           | apply sign
// PUT_Z          | strobe result and wait for downstream ack

module float_to_int (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_exc,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A         = 3'd0,
        UNPACK        = 3'd1,
        SPECIAL_CASES = 3'd2,
        CONVERT       = 3'd3,
        PACK          = 3'd4,
        PUT_Z         = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        m_q, m_d;
    logic signed [9:0]  e_q, e_d;
    logic               s_q, s_d;
    logic [31:0]        z_q, z_d;
    logic               exc_q, exc_d;
    logic               input_a_ack_q, input_a_ack_d;
    logic               output_z_stb_q, output_z_stb_d;
    logic [31:0]        output_z_q, output_z_d;
    logic               output_z_exc_q, output_z_exc_d;
    logic [31:0]        ovf_value;

    // Value returned for every exception case, selected by build option.
    always_comb begin
        ovf_value = 32'h8000_0000;
`ifdef F2I_SATURATE_EN
        if (a_q[30:23] == 8'hFF && a_q[22:0] != 23'd0) begin
            ovf_value = 32'h0000_0000;
        end else if (a_q[31]) begin
            ovf_value = 32'h8000_0000;
        end else begin
            ovf_value = 32'h7FFF_FFFF;
        end
`endif
    end

    // Next-state and datapath updates for each FSM state.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        m_d            = m_q;
        e_d            = e_q;
        s_d            = s_q;
        z_d            = z_q;
        exc_d          = exc_q;
        input_a_ack_d  = input_a_ack_q;
        output_z_stb_d = output_z_stb_q;
        output_z_d     = output_z_q;
        output_z_exc_d = output_z_exc_q;

        case (state_q)
            GET_A: begin
                input_a_ack_d = 1'b1;
                if (input_a_stb && input_a_ack_q) begin
                    a_d           = input_a;
                    input_a_ack_d = 1'b0;
                    state_d       = UNPACK;
                end
            end

            UNPACK: begin
                m_d     = {1'b1, a_q[22:0], 8'b0};
                e_d     = $signed({2'b00, a_q[30:23]}) - 10'sd127;
                s_d     = a_q[31];
                state_d = SPECIAL_CASES;
            end

            SPECIAL_CASES: begin
                if (a_q[30:23] == 8'hFF) begin
                    z_d     = ovf_value;
                    exc_d   = 1'b1;
                    state_d = PUT_Z;
                end else if (e_q < 10'sd0) begin
                    z_d     = 32'h0000_0000;
                    exc_d   = 1'b0;
                    state_d = PUT_Z;
                end else if (e_q == 10'sd31 && s_q && a_q[22:0] == 23'd0) begin
                    // -2^31 is the one representable value with e == 31
                    z_d     = 32'h8000_0000;
                    exc_d   = 1'b0;
                    state_d = PUT_Z;
                end else if (e_q >= 10'sd31) begin
                    z_d     = ovf_value;
                    exc_d   = 1'b1;
                    state_d = PUT_Z;
                end else begin
                    state_d = CONVERT;
                end
            end

            CONVERT: begin
                if (e_q == 10'sd31) begin
                    state_d = PACK;
                end else begin
                    m_d = m_q >> 1;
                    e_d = e_q + 10'sd1;
                end
            end

            PACK: begin
                z_d     = s_q ? (~m_q + 32'd1) : m_q;
                exc_d   = 1'b0;
                state_d = PUT_Z;
            end

            PUT_Z: begin
                output_z_stb_d = 1'b1;
                output_z_d     = z_q;
                output_z_exc_d = exc_q;
                if (output_z_stb_q && output_z_ack) begin
                    output_z_stb_d = 1'b0;
                    state_d        = GET_A;
                end
            end

            default: begin
                state_d = GET_A;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q        <= GET_A;
            a_q            <= 32'd0;
            m_q            <= 32'd0;
            e_q            <= 10'sd0;
            s_q            <= 1'b0;
            z_q            <= 32'd0;
            exc_q          <= 1'b0;
            input_a_ack_q  <= 1'b0;
            output_z_stb_q <= 1'b0;
            output_z_q     <= 32'd0;
            output_z_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            m_q            <= m_d;
            e_q            <= e_d;
            s_q            <= s_d;
            z_q            <= z_d;
            exc_q          <= exc_d;
            input_a_ack_q  <= input_a_ack_d;
            output_z_stb_q <= output_z_stb_d;
            output_z_q     <= output_z_d;
            output_z_exc_q <= output_z_exc_d;
        end
    end

    assign input_a_ack  = input_a_ack_q;
    assign output_z_stb = output_z_stb_q;
    assign output_z     = output_z_q;
    assign output_z_exc = output_z_exc_q;

endmodule

// File: doc/float_to_int.md
# float_to_int

Converts an IEEE-754 single-precision result into a signed 32-bit two's-complement integer, rounding toward zero. Sits directly downstream of the floating-point divider and takes its `output_z` / `output_z_stb` / `output_z_ack` stream on `input_a`. It produces an integer stream with the same strobe/acknowledge protocol, plus an exception flag. The shift is iterative, one bit per cycle, to match the divider's area-over-speed style.

## Interface
- No parameters.
- `CLOCK`  in  1  clock; all logic on rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `input_a`  in  32  IEEE-754 single operand.
- `input_a_stb`  in  1  upstream has a valid operand.
- `input_a_ack`  out  1  block ready to accept; a transfer occurs on any edge where `input_a_stb` and `input_a_ack` are both 1.
- `output_z`  out  32  signed integer result.
- `output_z_exc`  out  1  1 = operand was NaN, ±inf, or out of range; valid with `output_z`.
- `output_z_stb`  out  1  result valid.
- `output_z_ack`  in  1  downstream accepts; a transfer occurs on any edge where `output_z_stb` and `output_z_ack` are both 1.

## Operation
- **State encoding:** 3-bit register, get_a=0, unpack=1, special_cases=2, convert=3, pack=4, put_z=5.
- **get_a:** drive `input_a_ack`=1 (registered). On transfer, latch `a`, clear ack on the same edge, then go to unpack.
- **unpack:**
  - m = {1, a[22:0], 8'b0} (32 bits).
  - e = a[30:23] − 127, 10-bit signed.
  - s = a[31].
- **special_cases**, evaluated in this priority order:
  1. Exponent field 255 (NaN or ±inf): z = OVF value, exc = 1, go to put_z.
  2. e < 0, including zero and denormals: z = 0, exc = 0, go to put_z.
  3. e == 31 with s=1 and a[22:0]=0 (exactly −2^31): z = 32'h80000000, exc = 0, go to put_z.
  4. e ≥ 31: z = OVF value, exc = 1, go to put_z.
  5. Otherwise go to convert.
- **convert:** each cycle, if e == 31 go to pack; else m <= m >> 1 and e <= e + 1. Discarded bits are dropped (truncation).
- **pack:** z = s ? −m : m (32-bit two's complement), exc = 0, go to put_z.
- **put_z:**
  - Register `output_z_stb`=1 and drive `output_z`/`output_z_exc` from z/exc.
  - On transfer, clear stb on the same edge and go to get_a.
  - `output_z` and `output_z_exc` hold their value after the transfer until the next result.
- **OVF value** without the macro: 32'h80000000 for every exception case, regardless of sign.

## Timing
- **Reset values:** `input_a_ack`=0, `output_z_stb`=0, `output_z`=0, `output_z_exc`=0, state=get_a. `input_a_ack` rises on the first edge after RESET deasserts.
- **RESET priority:** RESET overrides every state. Asserted mid-operation (convert, or put_z with stb high), it aborts the conversion, emits no result, and discards the held operand.
- **Normal path latency,** with the operand accepted on edge T and exponent e in 0..30:
  - convert lasts 32−e cycles.
  - `output_z_stb` is high after edge T+36−e.
  - Range is T+6 (e=30) to T+36 (e=0).
- **Special-case latency:** `output_z_stb` high after edge T+3.
- **Throughput:** one operation at a time. `input_a_ack` stays 0 from the accepting edge until the cycle after the output transfer. No overlap, no buffering.
- **Backpressure:** while `output_z_ack`=0, `output_z`, `output_z_exc` and `output_z_stb` stay stable indefinitely.
- **Strobe timing:** `input_a_stb` may be high before ack rises. The first transfer happens on the first edge where both are high.

## Configuration
- **`F2I_SATURATE_EN` defined:** OVF value is chosen as follows; `output_z_exc` behaviour is unchanged.
  - Positive overflow and +inf: 32'h7FFFFFFF.
  - Negative overflow and −inf: 32'h80000000.
  - NaN: 32'h00000000.
- **`F2I_SATURATE_EN` undefined:** every exception case returns 32'h80000000 (x86 "integer indefinite" convention).
- Latency is identical in both builds.

## Test plan
- 32'h3F800000 (1.0) → `output_z`=32'h00000001, exc=0, stb high 36 edges after accept; 32'h4EFFFFFF → 32'h7FFFFF80, stb 6 edges after accept.
- 32'hC0300000 (−2.75) → 32'hFFFFFFFE, exc=0; 32'h3F000000 (0.5) → 0, exc=0; 32'h00000001 (denormal) → 0, exc=0, stb after 3 edges.
- 32'hCF000000 (−2^31) → 32'h80000000, exc=0; 32'h4F000000 (2^31) → 32'h80000000, exc=1 (no macro) / 32'h7FFFFFFF, exc=1 (with `F2I_SATURATE_EN`).
- 32'h7FC00000 (NaN) → exc=1, `output_z`=32'h80000000 (no macro) / 32'h00000000 (macro); 32'hFF800000 (−inf) → 32'h80000000, exc=1 in both builds.
- Backpressure: hold `output_z_ack`=0 for 10 cycles after stb rises → `output_z` and stb stable, `input_a_ack`=0 throughout, next operand accepted only after the ack.
- Reset mid-operation: accept 32'h3F800000, assert RESET for one cycle 10 edges later → no stb, all outputs 0, `input_a_ack`=1 one edge after release, next operand converted correctly.
